// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: UART register map, transmit FSM encodings and status bit indices.
// Shared with the receive path. Defines the `USR_addr, `UDRR_addr, `UDRT_addr
// and `UTSR_addr macros, which other data-memory files use.
// Optional parity is enabled with the UART_TX_PARITY_EN macro (see uart_tx.sv).
`ifndef UART_DEFS_VH
`define UART_DEFS_VH
`define USR_addr  32'h0000_0400
`define UDRR_addr 32'h0000_0404
`define UDRT_addr 32'h0000_0408
`define UTSR_addr 32'h0000_040C
`endif

package uart_tx_pkg;

    localparam logic [31:0] USR_ADDR  = `USR_addr;
    localparam logic [31:0] UDRR_ADDR = `UDRR_addr;
    localparam logic [31:0] UDRT_ADDR = `UDRT_addr;
    localparam logic [31:0] UTSR_ADDR = `UTSR_addr;

    // Transmit FSM encodings; PARITY is only reachable when parity is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // UTSR bit positions.
    localparam int THRE_BIT = 0;
    localparam int TXC_BIT  = 1;

    // Even-parity bit: XOR of the eight data bits.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period down-counter.
// On load it restarts at CLKS_PER_BIT-1. It then counts down to 0 and holds there.
// bit_done is high while the count is 0, which marks the last cycle of a bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped UART transmitter.
// The CPU stores a byte to `UDRT_addr. The byte waits in a one-entry holding
// register and is then sent LSB first, with 8N1 framing, on tx.
// UTSR[0] is THRE (holding register empty).
// UTSR[1] is TXC (holding register empty and the shifter idle).
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits
// and the stop bit.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int addr_size    = 32,
    parameter int cell_size    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [addr_size-1:0] addr_bus,
    input  logic [cell_size-1:0] data_bus_in,
    input  logic                 we,
    output logic                 tx,
    output logic [1:0]           UTSR
);

    tx_state_e  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       tx_q, tx_d;

    logic baud_load;
    logic bit_done;
    logic wr_acc;
    logic xfer;

    // Only the low byte of a store carries data.
    logic unused_data_hi;
    assign unused_data_hi = ^data_bus_in[cell_size-1:8];

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (baud_load),
        .bit_done (bit_done)
    );

    // A store is taken only when it targets the data register and the holding register is empty.
    assign wr_acc = we && (addr_bus == addr_size'(UDRT_ADDR)) && !hold_full_q;

    // Next-state logic: frame sequencing, holding-to-shifter transfer, and the registered tx value.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        baud_load   = 1'b0;
        xfer        = 1'b0;
        tx_d        = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    xfer    = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    idx_d     = 3'd0;
                    baud_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_load = 1'b1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d   = ST_STOP;
                    baud_load = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (hold_full_q) begin
                        // Chain the next frame without an idle gap.
                        xfer    = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A transfer and an accepted write never coincide, because accepting needs an empty holding register.
        if (xfer) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            baud_load   = 1'b1;
        end else if (wr_acc) begin
            hold_d      = data_bus_in[7:0];
            hold_full_d = 1'b1;
        end

        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = even_parity(shift_d);
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers. An asynchronous reset truncates any frame and forces tx high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            idx_q       <= 3'd0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            tx_q        <= tx_d;
        end
    end

    assign tx             = tx_q;
    assign UTSR[THRE_BIT] = !hold_full_q;
    assign UTSR[TXC_BIT]  = !hold_full_q && (state_q == ST_IDLE);

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Memory-mapped UART transmitter; counterpart of the receive path that feeds the USR/UDRR cells in data memory.
- CPU stores a byte to the transmit data register address `UDRT_addr. The block buffers it in a one-entry holding register and serializes it as 8N1, LSB first, on tx.
- Exports a 2-bit transmit status that data memory mirrors into a read-only cell, alongside USR.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (≥2).
- addr_size, 32, CPU address bus width.
- cell_size, 32, CPU data bus width; only bits [7:0] are used.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset; one clock; asynchronous, active-low.
- addr_bus  input  addr_size  CPU address.
- data_bus_in  input  cell_size  CPU store data.
- we  input  1  CPU write enable.
- tx  output  1  serial line; idle high.
- UTSR  output  2  status: [0] THRE (holding register empty), [1] TXC (holding empty and shifter idle).

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx=1, UTSR=2'b11.
  - Holding register empty; FSM IDLE; baud counter and bit index cleared.
  - Applies immediately, including mid-frame; the frame is truncated and tx returns high at once.
- Write acceptance:
  - A write is accepted at a posedge when we=1, addr_bus==`UDRT_addr and the holding register is empty (THRE=1).
  - On acceptance, data_bus_in[7:0] is latched into the holding register and THRE clears.
  - A write while THRE=0 is dropped silently and leaves the holding contents unchanged.
  - Writes to other addresses are ignored.
- FSM states:
  - IDLE: tx=1. If holding is full, move to START on the next edge, transfer holding to the shifter, set THRE=1, and load the baud counter with CLKS_PER_BIT-1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shifter[idx] for CLKS_PER_BIT cycles per bit; idx 0..7. After idx 7 expires, go to STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. When it expires: if holding is full, go straight to START with the transfer above (no idle gap); otherwise go to IDLE.
- Latency and timing:
  - tx is registered.
  - For a write accepted at edge E0, tx=0 from edge E0+1.
  - A frame is 10*CLKS_PER_BIT cycles (11 with parity).
  - Back-to-back frames are separated by exactly one stop bit.
- Baud counter: counts down from CLKS_PER_BIT-1 to 0; a bit period ends at 0; width is $clog2(CLKS_PER_BIT).
- Simultaneous events:
  - A write in the same cycle that holding→shifter transfer happens is dropped, because THRE was 0 at that edge.
  - A write is accepted on the edge following the transfer.
- UTSR encoding:
  - UTSR[0] = holding empty.
  - UTSR[1] = holding empty AND FSM==IDLE.
  - Both are registered or derived from registers only (no combinational path from we).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: after DATA, a PARITY state drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then STOP; frame length is 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; 8N1 framing.

Decomposition:
- Shared header uart_defs.vh holds:
  - `UDRT_addr and `UTSR_addr, next to the existing `USR_addr and `UDRR_addr;
  - the FSM state encodings (IDLE/START/DATA/PARITY/STOP, 3-bit);
  - status bit indices (THRE=0, TXC=1).
- One natural sub-module, uart_baud_gen: a CLKS_PER_BIT down-counter with load and bit_done outputs, reusable by the receiver.

Test Plan (CLKS_PER_BIT=4):
- Reset then idle, no writes: tx=1 and UTSR=2'b11 for 100 cycles.
- Write 0x55 to `UDRT_addr at E0:
  - THRE=0 after E0; THRE=1 after E0+1; TXC=0.
  - tx from E0+1 is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - TXC=1 at E0+41.
- Back-to-back: write 0xA3 while the frame for 0x55 is in DATA. The 0xA3 start bit begins exactly 4 cycles after the 0x55 stop bit begins; no extra idle cycles.
- Overrun: write 0x11 (shifter busy, holding empty), then 0x22 while THRE=0. Only 0x55, 0x11 appear on tx; 0x22 is never sent.
- Address filter: write 0xFF to `UDRT_addr+1 → tx stays 1 and UTSR unchanged.
- Reset mid-frame: pull rst_n low during DATA bit 3 of 0x0F → tx=1 in the same cycle (asynchronous); after release, UTSR=2'b11 and no residual frame is sent.
- UART_TX_PARITY_EN: write 0x07 (odd weight) → parity bit 1 precedes the stop bit; frame is 44 cycles.
